// File: rtl/sram_responder.sv
// sram_responder: on-chip stand-in for the external 1Mx16 async SRAM.
// Decodes the active-low CE/UB/LB/OE/WE pin set every cycle, clears the
// array after reset, and returns read data through a READ_LAT-deep pipeline.
// Optional build macro: SRAM_RESP_PROTOCOL_CHECK_EN adds a sticky Proto_err
// output flagging illegal pin combinations and out-of-range addresses.
module sram_responder #(
   parameter int ADDR_W   = 10,
   parameter int READ_LAT = 1
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        CE,
   input  logic        UB,
   input  logic        LB,
   input  logic        OE,
   input  logic        WE,
   input  logic [19:0] ADDR,
   input  logic [15:0] Data_write,
   output logic [15:0] Data_read,
   output logic        Data_oe,
`ifdef SRAM_RESP_PROTOCOL_CHECK_EN
   output logic        Proto_err,
`endif
   output logic        Init_done
);

   localparam int DEPTH = 1 << ADDR_W;

   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_IDLE  = 1'b1;

   logic [0:0]        state;
   logic [ADDR_W-1:0] clear_ptr;
   logic [15:0]       mem [DEPTH];

   logic              in_idle;
   logic              in_range;
   logic [ADDR_W-1:0] word_addr;
   logic              wr_en;
   logic              rd_issue;
   logic [15:0]       rd_word;

   logic              pipe_v [READ_LAT];
   logic [15:0]       pipe_d [READ_LAT];

   // Pin decode: one independent transaction per cycle, write wins over read.
   always_comb begin
      in_idle   = (state == ST_IDLE);
      in_range  = (ADDR[19:ADDR_W] == '0);
      word_addr = ADDR[ADDR_W-1:0];
      wr_en     = in_idle && !CE && !WE && in_range;
      rd_issue  = in_idle && !CE && !OE && WE && (!UB || !LB);
      rd_word   = 16'h0000;
      if (in_range) begin
         rd_word[15:8] = UB ? 8'h00 : mem[word_addr][15:8];
         rd_word[7:0]  = LB ? 8'h00 : mem[word_addr][7:0];
      end
   end

   // Clear sequencer: walks every word once after reset, then parks in IDLE.
   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state     <= ST_CLEAR;
         clear_ptr <= '0;
         Init_done <= 1'b0;
      end else if (state == ST_CLEAR) begin
         clear_ptr <= clear_ptr + ADDR_W'(1);
         if (&clear_ptr) begin
            state     <= ST_IDLE;
            Init_done <= 1'b1;
         end
      end
   end

   // Storage array: zero-fill during CLEAR, byte-lane writes in IDLE.
   // NOTE: the array has no reset branch; the CLEAR walk initialises it.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         if (state == ST_CLEAR) begin
            mem[clear_ptr] <= 16'h0000;
         end else if (wr_en) begin
            if (!UB) mem[word_addr][15:8] <= Data_write[15:8];
            if (!LB) mem[word_addr][7:0]  <= Data_write[7:0];
         end
      end
   end

   // Read pipeline: word sampled at issue, shifted READ_LAT stages to the pins.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < READ_LAT; i++) begin
            pipe_v[i] <= 1'b0;
            pipe_d[i] <= 16'h0000;
         end
      end else begin
         pipe_v[0] <= rd_issue;
         pipe_d[0] <= rd_issue ? rd_word : 16'h0000;
         for (int i = 1; i < READ_LAT; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_d[i] <= pipe_d[i-1];
         end
      end
   end

   // Data only ever enters the pipe alongside a valid bit, so the last stage
   // already reads zero whenever Data_oe is low.
   assign Data_oe   = pipe_v[READ_LAT-1];
   assign Data_read = pipe_d[READ_LAT-1];

`ifdef SRAM_RESP_PROTOCOL_CHECK_EN
   logic viol_rw;
   logic viol_nolane;
   logic viol_range;

   // Protocol violations are only meaningful once the bus is live.
   always_comb begin
      viol_rw     = in_idle && !CE && !WE && !OE;
      viol_nolane = in_idle && !CE && !WE && UB && LB;
      viol_range  = in_idle && !CE && !in_range;
   end

   // Sticky error flag, cleared only by Reset.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         Proto_err <= 1'b0;
      end else if (viol_rw || viol_nolane || viol_range) begin
         Proto_err <= 1'b1;
      end
   end

`ifndef SYNTHESIS
   // Simulation-only report naming each violation and the offending address.
   always @(posedge Clk) begin
      if (!Reset) begin
         if (viol_rw)     $error("sram_responder: WE and OE both low, ADDR=%05h", ADDR);
         if (viol_nolane) $error("sram_responder: write with no byte lane, ADDR=%05h", ADDR);
         if (viol_range)  $error("sram_responder: address out of range, ADDR=%05h", ADDR);
      end
   end
`endif
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench: three responders (READ_LAT 1/2/3, ADDR_W=4) share one bus.
// Expected responses are tracked per latency by a small issue history.
module tb_sram_responder;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        CE, UB, LB, OE, WE;
   logic [19:0] ADDR;
   logic [15:0] Data_write;

   logic [15:0] rd_l1, rd_l2, rd_l3;
   logic        oe_l1, oe_l2, oe_l3;
   logic        init_l1, init_l2, init_l3;
`ifdef SRAM_RESP_PROTOCOL_CHECK_EN
   logic        perr_l1, perr_l2, perr_l3;
`endif

   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;

   logic        cur_v;
   logic [15:0] cur_d;
   logic        exp_init;
   logic        ev [3];
   logic [15:0] ed [3];

   always #5 Clk = ~Clk;

   sram_responder #(.ADDR_W(4), .READ_LAT(1)) u_l1 (
      .Clk(Clk), .Reset(Reset), .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE),
      .ADDR(ADDR), .Data_write(Data_write), .Data_read(rd_l1), .Data_oe(oe_l1),
`ifdef SRAM_RESP_PROTOCOL_CHECK_EN
      .Proto_err(perr_l1),
`endif
      .Init_done(init_l1));

   sram_responder #(.ADDR_W(4), .READ_LAT(2)) u_l2 (
      .Clk(Clk), .Reset(Reset), .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE),
      .ADDR(ADDR), .Data_write(Data_write), .Data_read(rd_l2), .Data_oe(oe_l2),
`ifdef SRAM_RESP_PROTOCOL_CHECK_EN
      .Proto_err(perr_l2),
`endif
      .Init_done(init_l2));

   sram_responder #(.ADDR_W(4), .READ_LAT(3)) u_l3 (
      .Clk(Clk), .Reset(Reset), .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE),
      .ADDR(ADDR), .Data_write(Data_write), .Data_read(rd_l3), .Data_oe(oe_l3),
`ifdef SRAM_RESP_PROTOCOL_CHECK_EN
      .Proto_err(perr_l3),
`endif
      .Init_done(init_l3));

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s @cycle %0d observed=%h expected=%h", tag, cyc, obs, exp);
      end
   endtask

   task automatic set_bus(input logic ce, input logic we, input logic oe,
                          input logic ub, input logic lb,
                          input logic [19:0] addr, input logic [15:0] data);
      CE = ce; WE = we; OE = oe; UB = ub; LB = lb; ADDR = addr; Data_write = data;
   endtask

   task automatic bus_idle();
      set_bus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 20'h0, 16'h0);
      cur_v = 1'b0;
   endtask

   task automatic wr(input logic [19:0] addr, input logic [15:0] data,
                     input logic ub, input logic lb);
      set_bus(1'b0, 1'b0, 1'b1, ub, lb, addr, data);
      cur_v = 1'b0;
   endtask

   // exp is the hand-computed word the read must return.
   task automatic rd(input logic [19:0] addr, input logic ub, input logic lb,
                     input logic [15:0] exp);
      set_bus(1'b0, 1'b1, 1'b0, ub, lb, addr, 16'h0);
      cur_v = 1'b1;
      cur_d = exp;
   endtask

   // One clock: advance the issue history, then compare every instance.
   task automatic step();
      logic rst_now;
      rst_now = Reset;
      @(posedge Clk);
      #1;
      cyc++;
      if (rst_now) begin
         for (int i = 0; i < 3; i++) begin
            ev[i] = 1'b0;
            ed[i] = 16'h0;
         end
      end else begin
         ev[2] = ev[1]; ed[2] = ed[1];
         ev[1] = ev[0]; ed[1] = ed[0];
         ev[0] = cur_v; ed[0] = cur_v ? cur_d : 16'h0;
      end
      check("l1_oe",   16'(oe_l1), 16'(ev[0]));
      check("l1_data", rd_l1,      ed[0]);
      check("l2_oe",   16'(oe_l2), 16'(ev[1]));
      check("l2_data", rd_l2,      ed[1]);
      check("l3_oe",   16'(oe_l3), 16'(ev[2]));
      check("l3_data", rd_l3,      ed[2]);
      check("l1_init", 16'(init_l1), 16'(exp_init));
      check("l2_init", 16'(init_l2), 16'(exp_init));
      check("l3_init", 16'(init_l3), 16'(exp_init));
   endtask

   task automatic drain();
      bus_idle();
      for (int i = 0; i < 3; i++) step();
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         ev[i] = 1'b0;
         ed[i] = 16'h0;
      end
      cur_d    = 16'h0;
      exp_init = 1'b0;
      bus_idle();

      // Reset pulse, then CLEAR: Init_done must rise on the 16th clock.
      // A write driven throughout CLEAR must be ignored.
      Reset = 1'b1;
      step();
`ifdef SRAM_RESP_PROTOCOL_CHECK_EN
      check("perr_reset", 16'(perr_l1), 16'h0);
`endif
      Reset = 1'b0;
      wr(20'h3, 16'hFFFF, 1'b0, 1'b0);
      for (int i = 1; i <= 16; i++) begin
         exp_init = (i == 16);
         step();
      end

      // Every word reads back as zero, back-to-back.
      for (int a = 0; a < 16; a++) begin
         rd(20'(a), 1'b0, 1'b0, 16'h0000);
         step();
      end
      drain();

      // Word write then read next cycle.
      wr(20'h5, 16'hBEEF, 1'b0, 1'b0); step();
      rd(20'h5, 1'b0, 1'b0, 16'hBEEF); step();

      // Byte lanes: low-byte write, then single-lane reads.
      wr(20'h5, 16'h12AB, 1'b1, 1'b0); step();
      rd(20'h5, 1'b0, 1'b1, 16'hBE00); step();
      rd(20'h5, 1'b1, 1'b0, 16'h00AB); step();
      drain();

      // Pipelined reads; a later write must not disturb the in-flight 0x2 read.
      wr(20'h1, 16'hAAAA, 1'b0, 1'b0); step();
      wr(20'h2, 16'hBBBB, 1'b0, 1'b0); step();
      wr(20'h3, 16'hCCCC, 1'b0, 1'b0); step();
      rd(20'h1, 1'b0, 1'b0, 16'hAAAA); step();
      rd(20'h2, 1'b0, 1'b0, 16'hBBBB); step();
      rd(20'h3, 1'b0, 1'b0, 16'hCCCC); step();
      wr(20'h2, 16'h0000, 1'b0, 1'b0); step();
      rd(20'h2, 1'b0, 1'b0, 16'h0000); step();
      drain();

      // WE and OE both low: write only, no response.
      set_bus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20'h7, 16'h5555);
      cur_v = 1'b0;
      step();
      rd(20'h7, 1'b0, 1'b0, 16'h5555); step();

      // No-lane read and write, and CE high, change nothing.
      set_bus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 20'h5, 16'h0);
      cur_v = 1'b0;
      step();
      wr(20'h5, 16'hFFFF, 1'b1, 1'b1); step();
      set_bus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 20'h5, 16'h9999);
      cur_v = 1'b0;
      step();
      rd(20'h5, 1'b0, 1'b0, 16'hBEAB); step();

      // Range: top word in range; aliases of word 0 above it are dropped.
      wr(20'hF, 16'hA5A5, 1'b0, 1'b0); step();
      rd(20'hF, 1'b0, 1'b0, 16'hA5A5); step();
      wr(20'h80000, 16'h1234, 1'b0, 1'b0); step();
      wr(20'h00010, 16'h7777, 1'b0, 1'b0); step();
      rd(20'h0, 1'b0, 1'b0, 16'h0000); step();
      rd(20'h80000, 1'b0, 1'b0, 16'h0000); step();
      drain();
`ifdef SRAM_RESP_PROTOCOL_CHECK_EN
      check("perr_sticky", 16'(perr_l1), 16'h1);
`endif

      // Reset with reads in flight: longer-latency responses are flushed,
      // CLEAR restarts and wipes the array.
      rd(20'h5, 1'b0, 1'b0, 16'hBEAB); step();
      Reset    = 1'b1;
      exp_init = 1'b0;
      bus_idle();
      step();
      Reset = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         exp_init = (i == 16);
         step();
      end
      rd(20'h5, 1'b0, 1'b0, 16'h0000); step();
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
